hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RISC-V core. Works alongside the EX-stage forwarding mux selects.
- Generates the PC and pipeline-register write enables and the flush signals.
- Handles three events: load-use bubbles, EX-resolved jump/branch redirects, and multi-cycle data-memory waits.
- A wait timeout halts the core.

---
 rtl/hazard_stall_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: PC/pipeline-register enables and flushes for load-use,
// EX redirects and data-memory waits. Optional stall counter under HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned PERF_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [4:0]        ex_rd,
   input  logic              ex_reg_we,
   input  logic              ex_mem_read,
   input  logic              ex_redirect,
   input  logic              mem_dmem_req,
   input  logic              dmem_ack,
   output logic              pc_we,
   output logic              if_id_we,
   output logic              if_id_flush,
   output logic              id_ex_we,
   output logic              id_ex_flush,
   output logic              ex_mem_we,
   output logic              mem_wb_flush,
   output logic              halted
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] stall_cycles
`endif
);

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      HALT
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             freeze;
   logic             load_use;
   logic             mem_stall;

   assign load_use = ex_mem_read & ex_reg_we & (ex_rd != 5'd0) &
                     ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
   assign mem_stall = mem_dmem_req & ~dmem_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = wait_cnt;
      freeze       = 1'b0;
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_we     = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_we    = 1'b1;
      mem_wb_flush = 1'b0;
      halted       = 1'b0;

      unique case (state)
         RUN: begin
            if (mem_stall) begin
               freeze    = 1'b1;
               state_nxt = MEM_WAIT;
               cnt_nxt   = CNT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (!dmem_ack) begin
               freeze  = 1'b1;
               cnt_nxt = wait_cnt + CNT_W'(1);
               if ((MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT_LAST)) begin
                  state_nxt = HALT;
               end
            end else begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         end
         HALT: begin
            freeze = 1'b1;
            halted = 1'b1;
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = '0;
         end
      endcase

      // Reset overrides everything; otherwise freeze beats redirect beats load-use.
      if (rst) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_we     = 1'b0;
         id_ex_flush  = 1'b1;
         ex_mem_we    = 1'b0;
         mem_wb_flush = 1'b1;
         halted       = 1'b0;
      end else if (freeze) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         id_ex_we     = 1'b0;
         ex_mem_we    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_we       = 1'b0;
         if_id_we    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Saturating count of cycles in which the PC did not advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (!pc_we && (stall_cycles != {PERF_W{1'b1}})) begin
         stall_cycles <= stall_cycles + PERF_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed steps then randomized traffic
// checked against a cycle-level behavioural model of the sequencing rules.
module tb_hazard_stall_ctrl;

   localparam int unsigned MEM_TIMEOUT = 16;
   localparam int unsigned PERF_W      = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
   logic       ex_reg_we = 1'b0, ex_mem_read = 1'b0, ex_redirect = 1'b0;
   logic       mem_dmem_req = 1'b0, dmem_ack = 1'b0;
   logic       pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush, halted;
`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cycles;
`endif

   int total = 0;
   int bad   = 0;

   // Model state: waiting on memory, halted, number of consecutive stalled memory cycles.
   bit          m_wait = 1'b0;
   bit          m_halt = 1'b0;
   int unsigned m_n    = 0;
   longint unsigned m_perf = 0;

   hazard_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8), .PERF_W(PERF_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
      .mem_dmem_req(mem_dmem_req), .dmem_ack(dmem_ack),
      .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush), .id_ex_we(id_ex_we),
      .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we), .mem_wb_flush(mem_wb_flush), .halted(halted)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Expected {pc_we,if_id_we,if_id_flush,id_ex_we,id_ex_flush,ex_mem_we,mem_wb_flush,halted}.
   function automatic logic [7:0] model_out();
      bit hazard, frozen;
      bit pw, iw, ifl, iew, iefl, emw, mwf, h;
      hazard = ex_mem_read && ex_reg_we && (ex_rd != 0) &&
               ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
      frozen = m_halt || (m_wait && !dmem_ack) || (!m_wait && mem_dmem_req && !dmem_ack);
      {pw, iw, ifl, iew, iefl, emw, mwf, h} = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      if (rst) begin
         {pw, iw, iew, emw} = 4'b0000;
         {ifl, iefl, mwf}   = 3'b111;
      end else if (frozen) begin
         {pw, iw, iew, emw} = 4'b0000;
         mwf = 1'b1;
         h   = m_halt;
      end else if (ex_redirect) begin
         ifl  = 1'b1;
         iefl = 1'b1;
      end else if (hazard) begin
         pw   = 1'b0;
         iw   = 1'b0;
         iefl = 1'b1;
      end
      return {pw, iw, ifl, iew, iefl, emw, mwf, h};
   endfunction

   task automatic check(input string tag);
      logic [7:0] act, exp;
      act = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush, halted};
      exp = model_out();
      total++;
      assert (act === exp) else begin
         bad++;
         $error("FAIL %s: outputs got %b want %b", tag, act, exp);
      end
`ifdef HAZARD_PERF_CNT_EN
      total++;
      assert (stall_cycles === PERF_W'(m_perf)) else begin
         bad++;
         $error("FAIL %s_perf: stall_cycles got %0d want %0d", tag, stall_cycles, m_perf);
      end
`endif
   endtask

   task automatic model_clk(input logic pc_we_exp);
      if (rst) begin
         m_wait = 1'b0; m_halt = 1'b0; m_n = 0; m_perf = 0;
      end else begin
         if (!pc_we_exp && m_perf != (64'd1 << PERF_W) - 1) m_perf++;
         if (m_halt) begin
         end else if (m_wait) begin
            if (dmem_ack) begin
               m_wait = 1'b0; m_n = 0;
            end else begin
               m_n++;
               if (MEM_TIMEOUT != 0 && m_n == MEM_TIMEOUT) m_halt = 1'b1;
            end
         end else if (mem_dmem_req && !dmem_ack) begin
            m_wait = 1'b1; m_n = 1;
         end
      end
   endtask

   // One clock: drive at negedge, check 1ns later, advance the model at posedge.
   task automatic cyc(input string tag, input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd, input logic we,
                      input logic mr, input logic redir, input logic req, input logic ack);
      logic [7:0] e;
      @(negedge clk);
      rst = r; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
      ex_rd = rd; ex_reg_we = we; ex_mem_read = mr; ex_redirect = redir;
      mem_dmem_req = req; dmem_ack = ack;
      #1;
      check(tag);
      e = model_out();
      @(posedge clk);
      model_clk(e[7]);
   endtask

   task automatic idle(input string tag);
      cyc(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #1;
      check("reset_state");
      cyc("reset_hold", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle("run_default");

      cyc("load_use_rs2", 1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("after_bubble", 1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("load_use_rs1", 1'b0, 5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("load_rd_zero", 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("load_rs2_unused", 1'b0, 5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("redirect_over_lu", 1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("req_ack_same", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc("ack_no_req", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Memory wait with ack on the 4th cycle; redirect held during the wait is ignored.
      cyc("mw_req", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++)
         cyc("mw_wait", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc("mw_ack", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle("mw_back_run");

      // Ack cycle still honours a load-use hazard.
      cyc("mw_req2", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("mw_ack_lu", 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

      // Timeout: halted from the 16th cycle after the request, sticky until reset.
      for (int i = 0; i < 20; i++)
         cyc("timeout", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("halt_sticky", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc("halt_rst", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle("halt_cleared");

      // Asynchronous reset mid-wait at wait_cnt=7.
      for (int i = 0; i < 7; i++)
         cyc("pre_async", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      check("async_before");
      rst = 1'b1;
      #1;
      check("async_rst");
      @(posedge clk);
      model_clk(1'b0);
      idle("async_release");
      for (int i = 0; i < 17; i++)
         cyc("async_cnt_zero", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("rst2", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Random traffic: a busy-ack phase and a slow-ack phase that reaches timeouts.
      for (int i = 0; i < 3000; i++) begin
         bit slow;
         slow = (i >= 1500);
         cyc("random",
             ($urandom_range(0, slow ? 39 : 99) == 0),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 2) == 0),
             slow ? ($urandom_range(0, 9) == 0) : 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
